pipelined_cla_adder: RTL and testbench



---
 rtl/pipelined_cla_adder.sv | 134 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Carry-pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
// Each BLOCK-bit lookahead group is resolved in its own stage, so an operation takes NBLK cycles.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of BLOCK");
    end

    // Stage k of these arrays is pipeline register S(k+1).
    logic             valid_q [NBLK];
    logic             valid_d [NBLK];
    logic [WIDTH-1:0] a_q     [NBLK];
    logic [WIDTH-1:0] a_d     [NBLK];
    logic [WIDTH-1:0] b_q     [NBLK];
    logic [WIDTH-1:0] b_d     [NBLK];
    logic [WIDTH-1:0] s_q     [NBLK];
    logic [WIDTH-1:0] s_d     [NBLK];
    logic             c_q     [NBLK];
    logic             c_d     [NBLK];
    logic             cm_q    [NBLK];
    logic             cm_d    [NBLK];

    logic             src_valid [NBLK];
    logic [WIDTH-1:0] src_a     [NBLK];
    logic [WIDTH-1:0] src_b     [NBLK];
    logic [WIDTH-1:0] src_s     [NBLK];
    logic             src_c     [NBLK];

    logic [BLOCK-1:0] grp_g;
    logic [BLOCK-1:0] grp_p;
    logic [BLOCK:0]   grp_c;
    logic             advance;

    // Flattened sum-of-products carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0.
    function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] g,
                                                   input logic [BLOCK-1:0] p,
                                                   input logic c0);
        logic [BLOCK:0] c;
        logic           acc;
        logic           pp;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & c0);
        end
        return c;
    endfunction

    assign advance   = !valid_q[NBLK-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[NBLK-1];
    assign sum       = s_q[NBLK-1];
    assign cout      = c_q[NBLK-1];
    assign ovf       = cm_q[NBLK-1] ^ c_q[NBLK-1];

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;

        src_valid[0] = in_valid;
        src_a[0]     = in1;
        src_b[0]     = sub ? ~in2 : in2;
        src_s[0]     = '0;
        src_c[0]     = sub | cin;
        for (int k = 1; k < NBLK; k++) begin
            src_valid[k] = valid_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_s[k]     = s_q[k-1];
            src_c[k]     = c_q[k-1];
        end

        for (int k = 0; k < NBLK; k++) begin
            grp_g = src_a[k][k*BLOCK +: BLOCK] & src_b[k][k*BLOCK +: BLOCK];
            grp_p = src_a[k][k*BLOCK +: BLOCK] ^ src_b[k][k*BLOCK +: BLOCK];
            grp_c = cla_carries(grp_g, grp_p, src_c[k]);

            valid_d[k] = src_valid[k];
            a_d[k]     = src_a[k];
            b_d[k]     = src_b[k];
            s_d[k]     = src_s[k];
            s_d[k][k*BLOCK +: BLOCK] = grp_p ^ grp_c[BLOCK-1:0];
            c_d[k]     = grp_c[BLOCK];
            cm_d[k]    = grp_c[BLOCK-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBLK; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
                c_q[k]     <= 1'b0;
                cm_q[k]    <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < NBLK; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                s_q[k]     <= s_d[k];
                c_q[k]     <= c_d[k];
                cm_q[k]    <= cm_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector and streaming checks for pipelined_cla_adder (WIDTH=32, BLOCK=8).
module tb_pipelined_cla_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        su;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t        vecs [12];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [33:0] exp_q [$];
    logic        hold_prev = 1'b0;
    logic [34:0] prev_out;
    int          pops = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Independent reference: {ovf, cout, sum}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic su);
        logic [31:0] bb;
        logic [32:0] r;
        logic        o;
        bb = su ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {32'd0, (su ? 1'b1 : ci)};
        o  = (a[31] == bb[31]) && (r[31] != a[31]);
        return {o, r[32], r[31:0]};
    endfunction

    // Single op with out_ready high; starts and ends at a negedge.
    task automatic run_vec(input vec_t v, input string nm);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in1 = v.a; in2 = v.b; cin = v.ci; sub = v.su;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1 = $urandom; in2 = $urandom;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk({nm, "_early_valid"}, 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_sum"},   64'(sum),  64'(v.s));
        chk({nm, "_cout"},  64'(cout), 64'(v.co));
        chk({nm, "_ovf"},   64'(ovf),  64'(v.ov));
        @(negedge clk);
        chk({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    // One clock of streaming with scoreboard; starts and ends at a negedge.
    task automatic cycle(input logic iv, input logic orr);
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        su;
        a = $urandom; b = $urandom; ci = 1'($urandom); su = 1'($urandom);
        out_ready = orr;
        in_valid  = iv;
        in1 = a; in2 = b; cin = ci; sub = su;
        #1;
        if (hold_prev)
            chk("stall_stable", 64'({out_valid, ovf, cout, sum}), 64'(prev_out));
        if (out_valid && !orr)
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_valid && orr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(out_valid), 64'd0);
            end else begin
                chk("stream_result", 64'({ovf, cout, sum}), 64'(exp_q[0]));
                void'(exp_q.pop_front());
                pops++;
            end
        end
        if (iv && in_ready)
            exp_q.push_back(model(a, b, ci, su));
        hold_prev = out_valid && !orr;
        prev_out  = {out_valid, ovf, cout, sum};
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[9]  = '{32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[10] = '{32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        vecs[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_cout",      64'(cout),      64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Full-rate streaming: one result per cycle once the pipe is full.
        pops = 0;
        for (int i = 0; i < 100; i++) begin
            if (i >= 4)
                chk("stream_every_cycle", 64'(out_valid), 64'd1);
            cycle(1'b1, 1'b1);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
        chk("stream_count", 64'(pops), 64'd100);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Fixed 5-cycle backpressure with a full pipe.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Random valid/ready toggling.
        for (int i = 0; i < 150; i++) cycle(1'($urandom), 1'($urandom));
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        // Async reset with a stalled, full pipe.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum",       64'(sum),       64'd0);
        chk("mid_rst_cout",      64'(cout),      64'd0);
        chk("mid_rst_ovf",       64'(ovf),       64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        exp_q.delete();
        hold_prev = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_no_valid", 64'(out_valid), 64'd0);
            cycle(1'b0, 1'b1);
        end
        run_vec(vecs[6], "post_rst_vec");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
